// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: immediate format tag,
// RV opcode constants and the per-instruction decode result.
package imm_gen_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Fields are sized for the widest XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
        logic [XLEN_MAX-1:0] target;
    } imm_result_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational instruction decode into immediate, format tag, illegal flag and PC-relative target.
// Optional feature: define IMMGEN_CSR_EN to decode SYSTEM CSR address / zimm immediates.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output imm_result_t     o_res
);

    logic signed [XLEN_MAX-1:0] w_imm;
    logic        [XLEN_MAX-1:0] w_pc;
    logic        [XLEN_MAX-1:0] w_target;
    imm_type_e                  w_type;
    logic                       w_ill;
    logic                       w_has_tgt;

    assign w_pc = XLEN_MAX'(i_pc);

    always_comb begin
        w_imm     = '0;
        w_type    = IMM_NONE;
        w_ill     = 1'b0;
        w_has_tgt = 1'b0;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                w_type = IMM_I;
                w_imm  = XLEN_MAX'($signed(i_instr[31:20]));
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    w_type = IMM_I;
                    w_imm  = XLEN_MAX'($signed(i_instr[31:20]));
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_STORE: begin
                w_type = IMM_S;
                w_imm  = XLEN_MAX'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            OP_BRANCH: begin
                w_type    = IMM_B;
                w_has_tgt = 1'b1;
                w_imm     = XLEN_MAX'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                               i_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                w_type    = IMM_U;
                w_has_tgt = (i_instr[6:0] == OP_AUIPC);
                w_imm     = XLEN_MAX'($signed({i_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                w_type    = IMM_J;
                w_has_tgt = 1'b1;
                w_imm     = XLEN_MAX'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                               i_instr[30:21], 1'b0}));
            end
            OP_OP, OP_FENCE: begin
            end
            OP_OP32: begin
                w_ill = (XLEN != 64);
            end
            OP_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
                // funct3[2] selects the immediate (zimm) CSR forms
                if (i_instr[14]) begin
                    w_type = IMM_Z;
                    w_imm  = XLEN_MAX'(i_instr[19:15]);
                end else begin
                    w_type = IMM_I;
                    w_imm  = XLEN_MAX'(i_instr[31:20]);
                end
`else
                w_type = IMM_NONE;
`endif
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // JALR is excluded: its base register is not visible at decode.
    assign w_target = w_has_tgt ? (w_pc + w_imm) : '0;

    assign o_res = '{imm: w_imm, imm_type: w_type, illegal: w_ill, target: w_target};

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with valid/ready input, 1-cycle latency output register,
// a one-entry skid buffer and a saturating illegal-opcode counter. Optional: IMMGEN_CSR_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_target,
    output logic [CNT_W-1:0] illegal_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    imm_result_t      w_dec_p0;
    imm_result_t      r_out_p1;
    imm_result_t      r_skid_p1;
    logic             vld_p1;
    logic             r_skid_vld_p1;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_out_free;

    // p0: combinational decode of the presented instruction
    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .o_res   (w_dec_p0)
    );

    // Ready depends only on registered skid occupancy, never on out_ready.
    assign in_ready   = !r_skid_vld_p1 && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_out_free = !vld_p1 || out_ready;

    // p1: output register; skid takes the accepted entry when the output is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_out_p1      <= '0;
            r_cnt         <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_vld_p1) begin
                    r_out_p1      <= r_skid_p1;
                    vld_p1        <= 1'b1;
                    r_skid_vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= w_accept;
                    if (w_accept) begin
                        r_out_p1 <= w_dec_p0;
                    end
                end
            end else if (w_accept) begin
                r_skid_vld_p1 <= 1'b1;
            end
            if (w_accept && w_dec_p0.illegal) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_out_free && w_accept) begin
            r_skid_p1 <= w_dec_p0;
        end
    end

    assign out_valid   = vld_p1 && !reset;
    assign out_imm     = reset ? '0 : r_out_p1.imm[XLEN-1:0];
    assign out_type    = reset ? '0 : r_out_p1.imm_type;
    assign out_illegal = reset ? 1'b0 : r_out_p1.illegal;
    assign out_target  = reset ? '0 : r_out_p1.target[XLEN-1:0];
    assign illegal_cnt = reset ? '0 : r_cnt;

    // Upper halves of the wide result fields are dead in narrow builds.
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic w_unused_hi;
        assign w_unused_hi = ^{r_out_p1.imm[XLEN_MAX-1:XLEN], r_out_p1.target[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance (2-bit counter) and a 64-bit instance share stimulus
// and are checked against a behavioural decode model and in-order scoreboards.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [63:0] tgt;
    } res_t;

    localparam logic [6:0] OPS [14] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h67,
                                        7'h37, 7'h17, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  typ32;
    logic [1:0]  cnt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  typ64;
    logic [15:0] cnt64;

    int n_checks = 0;
    int n_err    = 0;
    res_t exp32_q[$], obs32_q[$], exp64_q[$], obs64_q[$];

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(typ32), .out_illegal(ill32), .out_target(tgt32),
        .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(typ64), .out_illegal(ill64), .out_target(tgt64),
        .illegal_cnt(cnt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode built from the immediate bit-placement rules with plain integer arithmetic.
    function automatic res_t model(input logic [31:0] ins, input logic [63:0] pc, input bit x64);
        res_t   r;
        longint v;
        longint t;
        bit     has_tgt;
        logic [6:0] op;
        op = ins[6:0];
        v = 0;
        has_tgt = 0;
        r.typ = IMM_NONE;
        r.ill = 1'b0;
        if (op == 7'h03 || op == 7'h13 || op == 7'h67 || (x64 && op == 7'h1B)) begin
            r.typ = IMM_I;
            v = ins[31:20];
            if (ins[31]) v -= 4096;
        end else if (op == 7'h23) begin
            r.typ = IMM_S;
            v = {ins[31:25], ins[11:7]};
            if (ins[31]) v -= 4096;
        end else if (op == 7'h63) begin
            r.typ = IMM_B;
            v = {ins[31], ins[7], ins[30:25], ins[11:8]};
            v = v * 2;
            if (ins[31]) v -= 8192;
            has_tgt = 1;
        end else if (op == 7'h37 || op == 7'h17) begin
            r.typ = IMM_U;
            v = ins[31:12];
            v = v * 4096;
            if (ins[31]) v -= 64'h1_0000_0000;
            has_tgt = (op == 7'h17);
        end else if (op == 7'h6F) begin
            r.typ = IMM_J;
            v = {ins[31], ins[19:12], ins[20], ins[30:21]};
            v = v * 2;
            if (ins[31]) v -= 2097152;
            has_tgt = 1;
        end else if (op == 7'h33 || op == 7'h0F || (x64 && op == 7'h3B)) begin
            r.typ = IMM_NONE;
        end else if (op == 7'h73) begin
`ifdef IMMGEN_CSR_EN
            if (ins[14]) begin
                r.typ = IMM_Z;
                v = ins[19:15];
            end else begin
                r.typ = IMM_I;
                v = ins[31:20];
            end
`else
            r.typ = IMM_NONE;
`endif
        end else begin
            r.ill = 1'b1;
        end
        t = has_tgt ? longint'(pc) + v : 0;
        r.imm = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
        r.tgt = x64 ? 64'(t) : (64'(t) & 64'hFFFF_FFFF);
        return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = OPS[$urandom_range(0, 13)];
        return w;
    endfunction

    // Records accepted inputs (as model results) and fired outputs; performs no comparisons.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && rdy32) exp32_q.push_back(model(in_instr, {32'b0, in_pc[31:0]}, 1'b0));
            if (in_valid && rdy64) exp64_q.push_back(model(in_instr, in_pc, 1'b1));
            if (vld32 && out_ready) obs32_q.push_back({32'b0, imm32, typ32, ill32, 32'b0, tgt32});
            if (vld64 && out_ready) obs64_q.push_back({imm64, typ64, ill64, tgt64});
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp32_q.delete(); obs32_q.delete(); exp64_q.delete(); obs64_q.delete();
    endtask

    // Present one instruction for a single cycle with out_ready high; returns out_valid seen before acceptance.
    task automatic drive_one(input logic [31:0] ins, input logic [63:0] pc, output logic pre_vld);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
        @(negedge clk);
        pre_vld = vld32;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int limit);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk); #1;
            if (obs32_q.size() >= exp32_q.size() && obs64_q.size() >= exp64_q.size()) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b0) begin
            n_err++; $display("FAIL reset_handshake: got %b required 0000", {vld32, rdy32, vld64, rdy64});
        end
        n_checks++;
        if ({imm32, typ32, ill32, tgt32, cnt32} !== '0) begin
            n_err++; $display("FAIL reset_fields32: imm %h type %0d ill %b tgt %h cnt %0d required all 0",
                              imm32, typ32, ill32, tgt32, cnt32);
        end
        n_checks++;
        if ({imm64, typ64, ill64, tgt64, cnt64} !== '0) begin
            n_err++; $display("FAIL reset_fields64: imm %h tgt %h cnt %0d required all 0", imm64, tgt64, cnt64);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy32 !== 1'b1 || vld32 !== 1'b0) begin
            n_err++; $display("FAIL post_reset_ready: in_ready %b out_valid %b required 1 0", rdy32, vld32);
        end
    endtask

    task automatic test_directed();
        logic pre;
        do_reset();
        drive_one(32'hFFF00093, 64'h0, pre);
        n_checks++;
        if (pre !== 1'b0 || vld32 !== 1'b1) begin
            n_err++; $display("FAIL addi_latency: valid before %b after %b required 0 1", pre, vld32);
        end
        n_checks++;
        if (imm32 !== 32'hFFFFFFFF || typ32 !== IMM_I || ill32 !== 1'b0) begin
            n_err++; $display("FAIL addi32: imm %h type %0d ill %b required ffffffff 1 0", imm32, typ32, ill32);
        end
        n_checks++;
        if (imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin
            n_err++; $display("FAIL addi64: imm %h required ffffffffffffffff", imm64);
        end
        drive_one(32'hFE000EE3, 64'h100, pre);
        n_checks++;
        if (imm32 !== 32'hFFFFFFFC || typ32 !== IMM_B || tgt32 !== 32'h000000FC) begin
            n_err++; $display("FAIL beq: imm %h type %0d tgt %h required fffffffc 3 000000fc", imm32, typ32, tgt32);
        end
        n_checks++;
        if (tgt64 !== 64'hFC) begin
            n_err++; $display("FAIL beq64_target: got %h required fc", tgt64);
        end
        drive_one(32'h0080006F, 64'h200, pre);
        n_checks++;
        if (imm32 !== 32'd8 || typ32 !== IMM_J || tgt32 !== 32'h208) begin
            n_err++; $display("FAIL jal: imm %h type %0d tgt %h required 8 5 208", imm32, typ32, tgt32);
        end
        drive_one(32'h123452B7, 64'h300, pre);
        n_checks++;
        if (imm32 !== 32'h12345000 || typ32 !== IMM_U || tgt32 !== 32'h0) begin
            n_err++; $display("FAIL lui: imm %h type %0d tgt %h required 12345000 4 0", imm32, typ32, tgt32);
        end
        drive_one(32'h800002B7, 64'h0, pre);
        n_checks++;
        if (imm64 !== 64'hFFFFFFFF_80000000 || imm32 !== 32'h80000000) begin
            n_err++; $display("FAIL lui_sext: imm64 %h imm32 %h required ffffffff80000000 80000000", imm64, imm32);
        end
        drive_one(32'h00001117, 64'h1000, pre);
        n_checks++;
        if (imm32 !== 32'h1000 || tgt32 !== 32'h2000 || typ32 !== IMM_U) begin
            n_err++; $display("FAIL auipc: imm %h tgt %h required 1000 2000", imm32, tgt32);
        end
        drive_one(32'h00808067, 64'h400, pre);
        n_checks++;
        if (imm32 !== 32'd8 || typ32 !== IMM_I || tgt32 !== 32'h0) begin
            n_err++; $display("FAIL jalr: imm %h type %0d tgt %h required 8 1 0", imm32, typ32, tgt32);
        end
        drive_one(32'h0000001B, 64'h0, pre);
        n_checks++;
        if (ill32 !== 1'b1 || ill64 !== 1'b0 || typ64 !== IMM_I) begin
            n_err++; $display("FAIL op_imm32: ill32 %b ill64 %b type64 %0d required 1 0 1", ill32, ill64, typ64);
        end
        drive_one(32'h0002D073, 64'h0, pre);
`ifdef IMMGEN_CSR_EN
        n_checks++;
        if (typ32 !== IMM_Z || imm32 !== 32'd5 || ill32 !== 1'b0) begin
            n_err++; $display("FAIL csrwi: type %0d imm %h ill %b required 6 5 0", typ32, imm32, ill32);
        end
`else
        n_checks++;
        if (typ32 !== IMM_NONE || imm32 !== 32'd0 || ill32 !== 1'b0) begin
            n_err++; $display("FAIL system: type %0d imm %h ill %b required 0 0 0", typ32, imm32, ill32);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int vld_cnt;
        do_reset();
        vld_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 6);
            in_instr = {12'(10 + i), 20'h00093};
            out_ready = 1'b1;
            @(negedge clk);
            if (i >= 1 && vld32 === 1'b1 && rdy32 === 1'b1) vld_cnt++;
        end
        drain(10);
        n_checks++;
        if (vld_cnt !== 6) begin
            n_err++; $display("FAIL b2b_throughput: valid+ready cycles %0d required 6", vld_cnt);
        end
        n_checks++;
        if (obs32_q.size() !== 6) begin
            n_err++; $display("FAIL b2b_count: got %0d required 6", obs32_q.size());
        end
        for (int i = 0; i < obs32_q.size() && i < 6; i++) begin
            n_checks++;
            if (obs32_q[i].imm !== 64'(10 + i)) begin
                n_err++; $display("FAIL b2b_order[%0d]: imm %h required %h", i, obs32_q[i].imm, 10 + i);
            end
        end
    endtask

    task automatic test_stall();
        int idx;
        bit saw_low;
        do_reset();
        idx = 0;
        saw_low = 0;
        for (int c = 0; c < 40 && (idx < 4 || obs32_q.size() < 4); c++) begin
            @(posedge clk); #1;
            in_valid = (idx < 4);
            in_instr = {12'(idx + 1), 20'h00093};
            out_ready = !(c >= 1 && c <= 3);
            @(negedge clk);
            if (in_valid && rdy32) idx++;
            if (!rdy32) saw_low = 1;
            #1;
        end
        drain(10);
        n_checks++;
        if (saw_low !== 1'b1) begin
            n_err++; $display("FAIL stall_ready_drop: saw in_ready low %b required 1", saw_low);
        end
        n_checks++;
        if (obs32_q.size() !== 4 || obs64_q.size() !== 4) begin
            n_err++; $display("FAIL stall_count: got %0d/%0d required 4", obs32_q.size(), obs64_q.size());
        end
        for (int i = 0; i < obs32_q.size() && i < 4; i++) begin
            n_checks++;
            if (obs32_q[i].imm !== 64'(i + 1) || obs32_q[i].typ !== IMM_I) begin
                n_err++; $display("FAIL stall_order[%0d]: imm %h required %h", i, obs32_q[i].imm, i + 1);
            end
        end
    endtask

    task automatic test_illegal_cnt();
        logic pre;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive_one(32'h0000007F | ($urandom & 32'hFFFFF000), {$urandom, $urandom}, pre);
            n_checks++;
            if (ill32 !== 1'b1 || imm32 !== 32'd0 || typ32 !== IMM_NONE || tgt32 !== 32'd0) begin
                n_err++; $display("FAIL illegal_fields[%0d]: ill %b imm %h type %0d tgt %h required 1 0 0 0",
                                  k, ill32, imm32, typ32, tgt32);
            end
            n_checks++;
            if (cnt32 !== 2'((k > 3) ? 3 : k) || cnt64 !== 16'(k)) begin
                n_err++; $display("FAIL illegal_cnt[%0d]: cnt32 %0d cnt64 %0d required %0d %0d",
                                  k, cnt32, cnt64, (k > 3) ? 3 : k, k);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        int n_ill32, n_ill64;
        do_reset();
        acc = 1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = gen_instr();
                in_pc = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = in_valid && rdy32;
        end
        drain(10);
        n_checks++;
        if (obs32_q.size() !== exp32_q.size() || obs64_q.size() !== exp64_q.size()) begin
            n_err++; $display("FAIL rand_count: out %0d/%0d required %0d/%0d",
                              obs32_q.size(), obs64_q.size(), exp32_q.size(), exp64_q.size());
        end
        n_ill32 = 0;
        n_ill64 = 0;
        for (int i = 0; i < exp32_q.size() && i < obs32_q.size(); i++) begin
            n_checks++;
            if (obs32_q[i] !== exp32_q[i]) begin
                n_err++; $display("FAIL rand32[%0d]: got %h required %h", i, obs32_q[i], exp32_q[i]);
            end
        end
        for (int i = 0; i < exp64_q.size() && i < obs64_q.size(); i++) begin
            n_checks++;
            if (obs64_q[i] !== exp64_q[i]) begin
                n_err++; $display("FAIL rand64[%0d]: got %h required %h", i, obs64_q[i], exp64_q[i]);
            end
        end
        foreach (exp32_q[i]) if (exp32_q[i].ill) n_ill32++;
        foreach (exp64_q[i]) if (exp64_q[i].ill) n_ill64++;
        n_checks++;
        if (cnt32 !== 2'((n_ill32 > 3) ? 3 : n_ill32) || cnt64 !== 16'(n_ill64)) begin
            n_err++; $display("FAIL rand_cnt: cnt32 %0d cnt64 %0d required %0d %0d",
                              cnt32, cnt64, (n_ill32 > 3) ? 3 : n_ill32, n_ill64);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_instr = (i == 0) ? 32'h0000007F : 32'h00000013;
            out_ready = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b1 || rdy32 !== 1'b0 || cnt32 !== 2'd1) begin
            n_err++; $display("FAIL midflight_full: valid %b ready %b cnt %0d required 1 0 1", vld32, rdy32, cnt32);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b0) begin
            n_err++; $display("FAIL midflight_in_reset: valid %b ready %b required 0 0", vld32, rdy32);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1 || cnt32 !== 2'd0 || vld64 !== 1'b0 || cnt64 !== 16'd0) begin
            n_err++; $display("FAIL midflight_after: valid %b ready %b cnt %0d required 0 1 0", vld32, rdy32, cnt32);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
            n_err++; $display("FAIL midflight_flushed: valid %b/%b required 0", vld32, vld64);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_pc = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_illegal_cnt();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
